// File: rtl/commit_trace_buffer_if.sv
// Interface bundling the write-back capture port and the trace drain port of
// commit_trace_buffer. The "slave" modport is the buffer itself; the "master"
// modport is the environment (MEM/WB stage on the input side, checker/logger
// on the output side).
// Optional feature macro: TRACE_CYCLE_STAMP_EN adds out_cycle[31:0].
interface commit_trace_buffer_if #(
    parameter int DEPTH  = 16,
    parameter int PC_W   = 16,
    parameter int DATA_W = 16
);
    localparam int CNT_W = $clog2(DEPTH) + 1;

    // Write-back capture side
    logic              wb_valid;
    logic [PC_W-1:0]   wb_pc;
    logic              wb_regwrite;
    logic [3:0]        wb_rd;
    logic [DATA_W-1:0] wb_data;
    logic              wb_hlt;

    // Trace drain side
    logic              out_valid;
    logic              out_ready;
    logic [15:0]       out_seq;
    logic [PC_W-1:0]   out_pc;
    logic [3:0]        out_rd;
    logic              out_regwrite;
    logic [DATA_W-1:0] out_data;
    logic              out_hlt;
`ifdef TRACE_CYCLE_STAMP_EN
    logic [31:0]       out_cycle;
`endif

    // Status
    logic [CNT_W-1:0]  count;
    logic              overflow;
    logic [7:0]        drop_cnt;
    logic              trace_done;

`ifdef TRACE_CYCLE_STAMP_EN
    modport master (
        output wb_valid, wb_pc, wb_regwrite, wb_rd, wb_data, wb_hlt, out_ready,
        input  out_valid, out_seq, out_pc, out_rd, out_regwrite, out_data, out_hlt,
        input  out_cycle,
        input  count, overflow, drop_cnt, trace_done
    );

    modport slave (
        input  wb_valid, wb_pc, wb_regwrite, wb_rd, wb_data, wb_hlt, out_ready,
        output out_valid, out_seq, out_pc, out_rd, out_regwrite, out_data, out_hlt,
        output out_cycle,
        output count, overflow, drop_cnt, trace_done
    );
`else
    modport master (
        output wb_valid, wb_pc, wb_regwrite, wb_rd, wb_data, wb_hlt, out_ready,
        input  out_valid, out_seq, out_pc, out_rd, out_regwrite, out_data, out_hlt,
        input  count, overflow, drop_cnt, trace_done
    );

    modport slave (
        input  wb_valid, wb_pc, wb_regwrite, wb_rd, wb_data, wb_hlt, out_ready,
        output out_valid, out_seq, out_pc, out_rd, out_regwrite, out_data, out_hlt,
        output count, overflow, drop_cnt, trace_done
    );
`endif

endinterface : commit_trace_buffer_if

// File: rtl/commit_trace_buffer.sv
// commit_trace_buffer
// Captures every retiring instruction from MEM/WB into an in-order commit
// record (seq#, PC, rd, regwrite, data, HLT), queues it in a DEPTH-entry FIFO
// and drains it over a valid/ready port. A retiring HLT closes the trace:
// further retirements are ignored, and trace_done rises once the queue has
// fully drained. Records arriving while full are dropped and counted.
// Optional feature macro: TRACE_CYCLE_STAMP_EN stamps every record with a
// free-running 32-bit cycle counter and exposes it on out_cycle.
module commit_trace_buffer #(
    parameter int DEPTH  = 16,
    parameter int PC_W   = 16,
    parameter int DATA_W = 16
) (
    input  logic                  clk,
    input  logic                  rst_n,
    commit_trace_buffer_if.slave  bus
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    typedef enum logic [1:0] {
        ST_RUN   = 2'd0,
        ST_DRAIN = 2'd1,
        ST_DONE  = 2'd2
    } state_t;

    typedef struct packed {
        logic [15:0]       seq;
        logic [PC_W-1:0]   pc;
        logic [3:0]        rd;
        logic              regwrite;
        logic [DATA_W-1:0] data;
        logic              hlt;
`ifdef TRACE_CYCLE_STAMP_EN
        logic [31:0]       cycle;
`endif
    } rec_t;

    // Storage and state
    rec_t              mem [DEPTH];
    state_t            state;
    logic [PTR_W-1:0]  wr_ptr;
    logic [PTR_W-1:0]  rd_ptr;
    logic [CNT_W-1:0]  count_q;
    logic [15:0]       seq_q;
    logic              overflow_q;
    logic [7:0]        drop_q;
    logic              done_q;
`ifdef TRACE_CYCLE_STAMP_EN
    logic [31:0]       cycle_q;
`endif

    // Per-cycle decisions
    logic              full;
    logic              out_valid;
    logic              push;
    logic              pop;
    logic              accept;
    logic              drop;
    logic [CNT_W-1:0]  count_nxt;
    rec_t              new_rec;
    rec_t              head;

    assign full      = (count_q == CNT_W'(DEPTH));
    assign out_valid = (count_q != '0);

    // A push is only attempted while the trace is open; the record is stored
    // unless the queue is full with no simultaneous pop to make room.
    assign push   = bus.wb_valid && (state == ST_RUN);
    assign pop    = out_valid && bus.out_ready;
    assign accept = push && (!full || pop);
    assign drop   = push && full && !pop;

    // Next occupancy from the accepted push / pop pair
    // NOTE: every always_comb output gets a default first so no path leaves it unassigned and infers a latch.
    always_comb begin
        count_nxt = count_q;
        case ({accept, pop})
            2'b10:   count_nxt = count_q + CNT_W'(1);
            2'b01:   count_nxt = count_q - CNT_W'(1);
            default: count_nxt = count_q;
        endcase
    end

    // Assemble the commit record for the instruction retiring this cycle
    always_comb begin
        new_rec          = '0;
        new_rec.seq      = seq_q;
        new_rec.pc       = bus.wb_pc;
        new_rec.rd       = bus.wb_rd;
        new_rec.regwrite = bus.wb_regwrite;
        new_rec.data     = bus.wb_data;
        new_rec.hlt      = bus.wb_hlt;
`ifdef TRACE_CYCLE_STAMP_EN
        new_rec.cycle    = cycle_q;
`endif
    end

    // Record storage; when full with a simultaneous pop, wr_ptr equals rd_ptr,
    // the head is read out this cycle and the slot is reused as the new tail.
    // NOTE: the record array carries no reset; stale contents are never visible because head fields are gated by out_valid.
    always_ff @(posedge clk) begin
        if (rst_n && accept) begin
            mem[wr_ptr] <= new_rec;
        end
    end

    // Pointers, occupancy, sequence counter and drop accounting
    // NOTE: sequential state is updated with non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            count_q    <= '0;
            seq_q      <= '0;
            overflow_q <= 1'b0;
            drop_q     <= '0;
        end else begin
            if (accept) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            count_q <= count_nxt;
            // Sequence advances on every attempt so drops leave visible gaps
            if (push) begin
                seq_q <= seq_q + 16'd1;
            end
            if (drop) begin
                overflow_q <= 1'b1;
                if (drop_q != 8'hFF) begin
                    drop_q <= drop_q + 8'd1;
                end
            end
        end
    end

    // Trace lifecycle: RUN until HLT retires, DRAIN until empty, then DONE
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state  <= ST_RUN;
            done_q <= 1'b0;
        end else begin
            case (state)
                ST_RUN: begin
                    if (push && bus.wb_hlt) begin
                        state <= ST_DRAIN;
                    end
                end
                ST_DRAIN: begin
                    if (count_nxt == '0) begin
                        state  <= ST_DONE;
                        done_q <= 1'b1;
                    end
                end
                ST_DONE: begin
                    done_q <= 1'b1;
                end
                default: begin
                    state  <= ST_RUN;
                    done_q <= 1'b0;
                end
            endcase
        end
    end

`ifdef TRACE_CYCLE_STAMP_EN
    // Free-running cycle counter used to stamp records
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cycle_q <= '0;
        end else begin
            cycle_q <= cycle_q + 32'd1;
        end
    end
`endif

    // Head record drive; fields read as zero whenever nothing is queued
    assign head             = mem[rd_ptr];
    assign bus.out_valid    = out_valid;
    assign bus.out_seq      = out_valid ? head.seq      : '0;
    assign bus.out_pc       = out_valid ? head.pc       : '0;
    assign bus.out_rd       = out_valid ? head.rd       : '0;
    assign bus.out_regwrite = out_valid ? head.regwrite : 1'b0;
    assign bus.out_data     = out_valid ? head.data     : '0;
    assign bus.out_hlt      = out_valid ? head.hlt      : 1'b0;
`ifdef TRACE_CYCLE_STAMP_EN
    assign bus.out_cycle    = out_valid ? head.cycle    : '0;
`endif

    assign bus.count      = count_q;
    assign bus.overflow   = overflow_q;
    assign bus.drop_cnt   = drop_q;
    assign bus.trace_done = done_q;

endmodule : commit_trace_buffer

// File: tb/tb_commit_trace_buffer.sv
// Self-checking bench for commit_trace_buffer.
// A queue-based reference model of the commit trace is compared against the
// DUT on every falling edge; directed scenarios add hand-computed literal
// expectations. Build with TRACE_CYCLE_STAMP_EN to cover the cycle stamp and
// the sequence counter wrap.
module tb_commit_trace_buffer;
    localparam int DEPTH  = 16;
    localparam int PC_W   = 16;
    localparam int DATA_W = 16;

    logic clk;
    logic rst_n;

    commit_trace_buffer_if #(.DEPTH(DEPTH), .PC_W(PC_W), .DATA_W(DATA_W)) bus ();

    commit_trace_buffer #(.DEPTH(DEPTH), .PC_W(PC_W), .DATA_W(DATA_W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    typedef struct {
        logic [15:0] seq;
        logic [15:0] pc;
        logic [3:0]  rd;
        logic        rw;
        logic [15:0] data;
        logic        hlt;
        logic [31:0] cyc;
    } rec_t;

    rec_t        mq[$];
    logic [15:0] m_seq;
    logic [31:0] m_cycle;
    logic [7:0]  m_drop;
    bit          m_ovf;
    bit          m_halted;
    bit          m_done;
    bit          model_on = 0;

    // Model advances at each rising edge from the inputs held across it
    initial begin
        forever begin
            bit   was_halted;
            bit   can_pop;
            rec_t r;
            @(posedge clk);
            if (!rst_n) begin
                mq.delete();
                m_seq    = 16'd0;
                m_cycle  = 32'd0;
                m_drop   = 8'd0;
                m_ovf    = 0;
                m_halted = 0;
                m_done   = 0;
                model_on = 1;
            end else begin
                was_halted = m_halted;
                can_pop    = (mq.size() > 0) && bus.out_ready;
                if (can_pop) void'(mq.pop_front());
                if (bus.wb_valid && !m_halted) begin
                    r.seq  = m_seq;
                    r.pc   = bus.wb_pc;
                    r.rd   = bus.wb_rd;
                    r.rw   = bus.wb_regwrite;
                    r.data = bus.wb_data;
                    r.hlt  = bus.wb_hlt;
                    r.cyc  = m_cycle;
                    if (mq.size() < DEPTH) begin
                        mq.push_back(r);
                    end else begin
                        m_ovf = 1;
                        if (m_drop != 8'd255) m_drop = m_drop + 8'd1;
                    end
                    m_seq = m_seq + 16'd1;
                    if (bus.wb_hlt) m_halted = 1;
                end
                if (was_halted && !m_done && mq.size() == 0) m_done = 1;
                m_cycle = m_cycle + 32'd1;
            end
        end
    end

    // Compare DUT against the model away from the active edge
    initial begin
        forever begin
            @(negedge clk);
            if (model_on) begin
                check("out_valid",  64'(bus.out_valid),  64'(mq.size() != 0));
                check("count",      64'(bus.count),      64'(mq.size()));
                check("overflow",   64'(bus.overflow),   64'(m_ovf));
                check("drop_cnt",   64'(bus.drop_cnt),   64'(m_drop));
                check("trace_done", 64'(bus.trace_done), 64'(m_done));
                if (mq.size() != 0) begin
                    check("out_seq",      64'(bus.out_seq),      64'(mq[0].seq));
                    check("out_pc",       64'(bus.out_pc),       64'(mq[0].pc));
                    check("out_rd",       64'(bus.out_rd),       64'(mq[0].rd));
                    check("out_regwrite", 64'(bus.out_regwrite), 64'(mq[0].rw));
                    check("out_data",     64'(bus.out_data),     64'(mq[0].data));
                    check("out_hlt",      64'(bus.out_hlt),      64'(mq[0].hlt));
`ifdef TRACE_CYCLE_STAMP_EN
                    check("out_cycle",    64'(bus.out_cycle),    64'(mq[0].cyc));
`endif
                end
            end
        end
    end

    // ---------------- stimulus helpers ----------------
    // Drive one cycle of inputs, then return at the following falling edge
    task automatic cyc(input bit v, input logic [15:0] pc, input bit hlt, input bit rdy);
        bus.wb_valid    = v;
        bus.wb_pc       = pc;
        bus.wb_rd       = pc[4:1];
        bus.wb_regwrite = pc[1];
        bus.wb_data     = pc ^ 16'hA5A5;
        bus.wb_hlt      = hlt;
        bus.out_ready   = rdy;
        @(negedge clk);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        cyc(0, 16'h0, 0, 0);
        rst_n = 1'b1;
    endtask

    initial begin
        #10_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    // ---------------- directed scenarios ----------------
    initial begin
        rst_n = 1'b0;
        cyc(0, 16'h0, 0, 0);
        cyc(0, 16'h0, 0, 0);
        rst_n = 1'b1;

        // Reset state
        check("rst out_valid",  64'(bus.out_valid),  64'd0);
        check("rst count",      64'(bus.count),      64'd0);
        check("rst overflow",   64'(bus.overflow),   64'd0);
        check("rst drop_cnt",   64'(bus.drop_cnt),   64'd0);
        check("rst trace_done", 64'(bus.trace_done), 64'd0);
        check("rst out_pc",     64'(bus.out_pc),     64'd0);

        // Three pushes with the consumer always ready
        cyc(1, 16'h0000, 0, 1);
        check("t1 first valid", 64'(bus.out_valid), 64'd1);
        check("t1 seq0",        64'(bus.out_seq),   64'd0);
        cyc(1, 16'h0002, 0, 1);
        check("t1 seq1",        64'(bus.out_seq),   64'd1);
        check("t1 pc1",         64'(bus.out_pc),    64'h2);
        cyc(1, 16'h0004, 0, 1);
        check("t1 seq2",        64'(bus.out_seq),   64'd2);
        check("t1 pc2",         64'(bus.out_pc),    64'h4);
        cyc(0, 16'h0, 0, 1);
        check("t1 drained",     64'(bus.out_valid), 64'd0);

        // Overfill by two with the consumer stalled, then drain in order
        do_reset();
        for (int i = 0; i < DEPTH + 2; i++) cyc(1, 16'(i * 2), 0, 0);
        check("t2 count full", 64'(bus.count),    64'd16);
        check("t2 overflow",   64'(bus.overflow), 64'd1);
        check("t2 drop_cnt",   64'(bus.drop_cnt), 64'd2);
        for (int i = 0; i < DEPTH; i++) begin
            check("t2 drain seq", 64'(bus.out_seq), 64'(i));
            check("t2 drain pc",  64'(bus.out_pc),  64'(i * 2));
            cyc(0, 16'h0, 0, 1);
        end
        check("t2 empty", 64'(bus.count), 64'd0);

        // Full FIFO with push and pop in the same cycle
        do_reset();
        for (int i = 0; i < DEPTH; i++) cyc(1, 16'(i * 2), 0, 0);
        check("t3 full",      64'(bus.count),   64'd16);
        check("t3 head seq0", 64'(bus.out_seq), 64'd0);
        cyc(1, 16'h0100, 0, 1);
        check("t3 count",     64'(bus.count),    64'd16);
        check("t3 no drop",   64'(bus.drop_cnt), 64'd0);
        check("t3 no ovf",    64'(bus.overflow), 64'd0);
        check("t3 head seq1", 64'(bus.out_seq),  64'd1);
        for (int i = 0; i < DEPTH - 1; i++) cyc(0, 16'h0, 0, 1);
        check("t3 tail seq",  64'(bus.out_seq), 64'd16);
        check("t3 tail pc",   64'(bus.out_pc),  64'h100);
        check("t3 tail cnt",  64'(bus.count),   64'd1);
        cyc(0, 16'h0, 0, 1);

        // HLT closes the trace; later retirements are ignored
        do_reset();
        cyc(1, 16'h0000, 0, 0);
        cyc(1, 16'h0002, 0, 0);
        cyc(1, 16'h0010, 1, 0);
        check("t4 count3", 64'(bus.count), 64'd3);
        for (int i = 0; i < 3; i++) cyc(1, 16'h0020, 0, 0);
        check("t4 ignored",    64'(bus.count),      64'd3);
        check("t4 not done",   64'(bus.trace_done), 64'd0);
        cyc(1, 16'h0030, 0, 1);
        check("t4 seq1",       64'(bus.out_seq),    64'd1);
        cyc(1, 16'h0030, 0, 1);
        check("t4 hlt head",   64'(bus.out_hlt),    64'd1);
        check("t4 hlt pc",     64'(bus.out_pc),     64'h10);
        check("t4 hlt seq",    64'(bus.out_seq),    64'd2);
        check("t4 done early", 64'(bus.trace_done), 64'd0);
        cyc(1, 16'h0030, 0, 1);
        check("t4 done",       64'(bus.trace_done), 64'd1);
        check("t4 empty",      64'(bus.out_valid),  64'd0);
        cyc(1, 16'h0040, 0, 1);
        cyc(1, 16'h0040, 0, 1);
        check("t4 done sticky", 64'(bus.trace_done), 64'd1);
        check("t4 still empty", 64'(bus.count),      64'd0);

        // Reset while draining with five records queued
        do_reset();
        for (int i = 0; i < 4; i++) cyc(1, 16'(i * 2), 0, 0);
        cyc(1, 16'h0008, 1, 0);
        check("t5 count5", 64'(bus.count), 64'd5);
        rst_n = 1'b0;
        cyc(1, 16'h0040, 0, 0);
        rst_n = 1'b1;
        check("t5 flushed",   64'(bus.count),     64'd0);
        check("t5 no valid",  64'(bus.out_valid), 64'd0);
        cyc(1, 16'h0050, 0, 0);
        check("t5 seq reset", 64'(bus.out_seq),   64'd0);
        check("t5 run pc",    64'(bus.out_pc),    64'h50);
        check("t5 run count", 64'(bus.count),     64'd1);

`ifdef TRACE_CYCLE_STAMP_EN
        // Cycle stamps at cycles 4 and 9 after reset
        do_reset();
        for (int i = 0; i < 4; i++) cyc(0, 16'h0, 0, 0);
        cyc(1, 16'h0060, 0, 0);
        for (int i = 0; i < 4; i++) cyc(0, 16'h0, 0, 0);
        cyc(1, 16'h0062, 0, 0);
        check("stamp 4", 64'(bus.out_cycle), 64'd4);
        cyc(0, 16'h0, 0, 1);
        check("stamp 9", 64'(bus.out_cycle), 64'd9);
        cyc(0, 16'h0, 0, 1);

        // Sequence counter wrap after 65536 pushes
        do_reset();
        for (int i = 0; i < 65536; i++) cyc(1, 16'(i), 0, 1);
        check("wrap seq ffff", 64'(bus.out_seq), 64'hFFFF);
        cyc(1, 16'h0000, 0, 1);
        check("wrap seq 0",    64'(bus.out_seq), 64'h0);
        cyc(0, 16'h0, 0, 1);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule : tb_commit_trace_buffer
